// File: rtl/key_debounce.sv
// Multi-channel pushbutton debouncer.
// Each raw active-low key is synchronized, then a per-channel four-state FSM
// with a stability counter accepts a level change only after the synchronized
// sample has held steady long enough. Emits a registered debounced level plus
// one-cycle press/release pulses per key.

module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_db,
  output logic press,
  output logic rel
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta, sample;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             db_nxt, press_nxt, rel_nxt;

  // Two-flop synchronizer; idles high so a held key is re-seen after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sample    <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sample    <= sync_meta;
    end
  end

  // State and stability counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: any reversal in a WAIT state aborts; counter saturates at CNT_MAX
  // because reaching it always leaves the WAIT state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (!sample) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sample) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sample) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!sample) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    db_nxt    = !((state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT));
    press_nxt = (state == PRESS_WAIT)   && (state_nxt == PRESSED);
    rel_nxt   = (state == RELEASE_WAIT) && (state_nxt == RELEASED);
  end

  // Registered outputs, changing on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_db <= 1'b1;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      key_db <= db_nxt;
      press  <= press_nxt;
      rel    <= rel_nxt;
    end
  end

endmodule

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_KEYS        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_db_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // One fully independent channel per key.
  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n_i[k]),
        .key_db(key_db_o[k]),
        .press (press_o[k]),
        .rel   (release_o[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (DEBOUNCE_CYCLES=8, NUM_KEYS=4).
// Stimulus pushes expected pulse events (cycle, press, release, level);
// a monitor pops and compares whenever the DUT emits a pulse.

module tb_key_debounce;

  localparam int D   = 8;
  localparam int NK  = 4;
  localparam int LAT = D + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n_i;
  logic [NK-1:0] key_db_o, press_o, release_o;

  key_debounce #(.DEBOUNCE_CYCLES(D), .NUM_KEYS(NK)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .key_n_i  (key_n_i),
    .key_db_o (key_db_o),
    .press_o  (press_o),
    .release_o(release_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  db;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int lat, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] d);
    exp_t e;
    e.cyc = cyc + lat; e.press = p; e.rel = r; e.db = d;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      chk("no_same_cycle_press_release", int'(press_o & release_o), 0);
      if ((press_o | release_o) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'({press_o, release_o}), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_cycle",   cyc,             e.cyc);
          chk("press_o",       int'(press_o),   int'(e.press));
          chk("release_o",     int'(release_o), int'(e.rel));
          chk("key_db_o",      int'(key_db_o),  int'(e.db));
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    key_n_i = 4'hF;
    #1;
    chk("reset_db",      int'(key_db_o),  'hF);
    chk("reset_press",   int'(press_o),   0);
    chk("reset_release", int'(release_o), 0);
    wait_neg(3);
    reset = 1'b0;
    wait_neg(3);

    // Clean press/release on key 0
    key_n_i = 4'hE; push(LAT, 4'h1, 4'h0, 4'hE);
    wait_neg(20);
    chk("k0_db_held", int'(key_db_o), 'hE);
    key_n_i = 4'hF; push(LAT, 4'h0, 4'h1, 4'hF);
    wait_neg(20);

    // Bouncing key 1: low runs of 3,5,7,4 separated by short highs
    key_n_i = 4'hD; wait_neg(3);
    key_n_i = 4'hF; wait_neg(2);
    key_n_i = 4'hD; wait_neg(5);
    key_n_i = 4'hF; wait_neg(3);
    key_n_i = 4'hD; wait_neg(7);
    key_n_i = 4'hF; wait_neg(2);
    key_n_i = 4'hD; wait_neg(4);
    key_n_i = 4'hF; wait_neg(2);
    chk("k1_db_during_bounce", int'(key_db_o), 'hF);
    key_n_i = 4'hD; push(LAT, 4'h2, 4'h0, 4'hD);
    wait_neg(20);
    key_n_i = 4'hF; push(LAT, 4'h0, 4'h2, 4'hF);
    wait_neg(20);

    // All keys at once
    key_n_i = 4'h0; push(LAT, 4'hF, 4'h0, 4'h0);
    wait_neg(20);
    key_n_i = 4'hF; push(LAT, 4'h0, 4'hF, 4'hF);
    wait_neg(20);

    // Reset five cycles into PRESS_WAIT on key 2, key kept held
    key_n_i = 4'hB;
    wait_neg(8);
    reset = 1'b1;
    #1;
    chk("midwait_reset_db",      int'(key_db_o),  'hF);
    chk("midwait_reset_press",   int'(press_o),   0);
    chk("midwait_reset_release", int'(release_o), 0);
    wait_neg(3);
    reset = 1'b0; push(LAT, 4'h4, 4'h0, 4'hB);
    wait_neg(20);
    key_n_i = 4'hF; push(LAT, 4'h0, 4'h4, 4'hF);
    wait_neg(20);

    // Key 3 held for 1000 cycles: one press, level stays low
    key_n_i = 4'h7; push(LAT, 4'h8, 4'h0, 4'h7);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i >= LAT) chk("k3_db_held_low", int'(key_db_o[3]), 0);
    end
    key_n_i = 4'hF; push(LAT, 4'h0, 4'h8, 4'hF);
    wait_neg(20);

    chk("scoreboard_drained", sb.size(), 0);
    chk("final_db", int'(key_db_o), 'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 The block SHALL have parameter NUM_KEYS, default 4, giving the number of independent key channels.
REQ-003 Port clk, input, 1 bit: the single system clock (50 MHz board clock); all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port key_n_i, input, NUM_KEYS bits: raw, asynchronous, active-low pushbutton pins (0 = pressed).
REQ-006 Port key_db_o, output, NUM_KEYS bits: debounced level, active-low, registered; drives the system's pushbutton PIO input directly.
REQ-007 Port press_o, output, NUM_KEYS bits: one-clock pulse per accepted press, per key.
REQ-008 Port release_o, output, NUM_KEYS bits: one-clock pulse per accepted release, per key.

Function
REQ-009 Each key_n_i bit SHALL pass through a dedicated 2-flop synchronizer; only the second flop ("sample") SHALL feed the channel logic.
REQ-010 Each channel SHALL contain an independent FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and an independent counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 RELEASED: sample=0 -> PRESS_WAIT with counter cleared to 0; otherwise hold.
REQ-012 PRESS_WAIT: sample=1 -> RELEASED, counter cleared; sample=0 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; sample=0 otherwise -> counter increments by 1.
REQ-013 PRESSED: sample=1 -> RELEASE_WAIT with counter cleared to 0; otherwise hold.
REQ-014 RELEASE_WAIT: sample=0 -> PRESSED, counter cleared; sample=1 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; sample=1 otherwise -> counter increments by 1.
REQ-015 key_db_o bit SHALL be 0 exactly while the channel is in PRESSED or RELEASE_WAIT, and 1 in RELEASED or PRESS_WAIT, registered with the state.
REQ-016 press_o bit SHALL be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED transition; release_o likewise for RELEASE_WAIT->RELEASED.
REQ-017 Latency: a clean raw edge held stable SHALL change key_db_o exactly DEBOUNCE_CYCLES+3 rising clk edges after the first edge at which the raw level is sampled, with the pulse asserted in that same cycle.
REQ-018 Any sample reversal during a WAIT state SHALL abort the change with no output change and no pulse; bounces shorter than DEBOUNCE_CYCLES SHALL never produce a pulse.
REQ-019 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 press_o and release_o of one channel SHALL never be asserted in the same cycle; pulses of different channels MAY coincide.
REQ-021 Channels SHALL not interact; simultaneous presses on several keys SHALL each be accepted with identical latency.

Reset
REQ-022 Asserting reset SHALL immediately, without a clock, set synchronizer flops to 1, all FSMs to RELEASED, counters to 0, key_db_o to all-ones, press_o and release_o to all-zeros.
REQ-023 Reset asserted mid-WAIT or in PRESSED SHALL discard the pending/accepted state without emitting any pulse; after deassertion, a key still held SHALL be re-accepted as a fresh press after full latency.
REQ-024 Deassertion SHALL be synchronous to clk by the integrating top level; the block SHALL assume no further reset handling.

Verification (bench uses DEBOUNCE_CYCLES=8, NUM_KEYS=4)
REQ-025 Reset with key_n_i=4'hF -> key_db_o=4'hF, press_o=0, release_o=0 before any clock edge.
REQ-026 key_n_i[0] 1->0 held -> key_db_o=4'hE and press_o=4'h1 for one cycle, exactly 11 edges after the first sampling edge; release 0->1 held -> key_db_o=4'hF, release_o=4'h1 11 edges later.
REQ-027 key_n_i[1] bounces 0/1 with low periods of 3-7 cycles, then stable 0 -> single press_o[1] pulse, 11 edges after the final stable fall; no pulse during bouncing.
REQ-028 key_n_i 4'hF->4'h0 in one cycle -> press_o=4'hF in one cycle, key_db_o=4'h0 together.
REQ-029 Reset asserted 5 cycles into PRESS_WAIT on key 2, key held -> no pulse; after deassert, press_o[2] 11 edges after first post-reset sampling edge.
REQ-030 Key 3 held pressed 1000 cycles -> exactly one press_o[3] pulse, key_db_o[3] stays 0 throughout, counter never exceeds 7.
